pocket_event_manager: RTL and testbench

- Consumes the hit pulse/level and hole index produced by the hole-collision stage.
- Turns each new pocketing into a timed sink animation, a score update for the current player, and a respawn handshake with the ball-motion block.
- Tracks turn ownership for two players and flags game over.
- Sits between the hit-controller collision logic and the ball drawing/motion and score display blocks.

---
 rtl/billiard_pkg.sv | 25 ++
 rtl/rise_detect.sv | 22 ++
 rtl/pocket_event_manager.sv | 129 ++++++++++++
 tb/tb_pocket_event_manager.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard hit-controller blocks.
package billiard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SINKING,
        SCORE,
        RESPAWN
    } pocket_state_t;

    localparam int MAX_SCORE = 99;
    localparam int PLAYER_W  = 1;

    // Score increment that holds at MAX_SCORE instead of wrapping.
    function automatic logic [6:0] sat_inc(input logic [6:0] s);
        logic [6:0] r;
        if (s >= 7'(MAX_SCORE)) begin
            r = 7'(MAX_SCORE);
        end else begin
            r = s + 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: rise is high for the first cycle that in is high.
module rise_detect (
    input  logic clk,
    input  logic resetN,
    input  logic in,
    output logic rise
);

    logic inD;

    // Delay the input by one cycle for comparison.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            inD <= 1'b0;
        end else begin
            inD <= in;
        end
    end

    assign rise = in & ~inD;

endmodule

// File: rtl/pocket_event_manager.sv
// Turns pocketing events into a sink animation, a score update and a
// respawn handshake; tracks turn ownership and game over.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ball on table, waiting for a valid hole hit
// SINKING | ball hidden, sinkFrame advances once per video frame
// SCORE   | one cycle: credit current player, raise respawn request
// RESPAWN | hold respawnReq until the motion block acknowledges
module pocket_event_manager
    import billiard_pkg::*;
#(
    parameter int SINK_FRAMES = 8,
    parameter int WIN_SCORE   = 7,
    parameter int NUM_HOLES   = 6
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                holeHit,
    input  logic [2:0]          holeNumberHit,
    input  logic                turnEnd,
    input  logic                respawnAck,
    output logic                ballVisible,
    output logic [3:0]          sinkFrame,
    output logic                respawnReq,
    output logic [PLAYER_W-1:0] currentPlayer,
    output logic [6:0]          score0,
    output logic [6:0]          score1,
    output logic [2:0]          lastHole,
    output logic                gameOver
);

    localparam logic [3:0] LAST_FRAME = 4'(SINK_FRAMES - 1);

    pocket_state_t state;
    logic          hitRise;
    logic          potFlag;
    logic          holeValid;
    logic          reachWin;
    logic [6:0]    curScore;
    logic [6:0]    nextScore;

    rise_detect uHitRise (
        .clk    (clk),
        .resetN (resetN),
        .in     (holeHit),
        .rise   (hitRise)
    );

    // Hole range check and the score the current player would get if credited now.
    always_comb begin
        holeValid = ({29'd0, holeNumberHit} < 32'(NUM_HOLES));
        curScore  = (currentPlayer != '0) ? score1 : score0;
        nextScore = sat_inc(curScore);
        reachWin  = ({25'd0, nextScore} >= 32'(WIN_SCORE));
    end

    // Pocketing sequence, scoring and turn ownership with registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            ballVisible   <= 1'b1;
            sinkFrame     <= 4'd0;
            respawnReq    <= 1'b0;
            currentPlayer <= '0;
            score0        <= 7'd0;
            score1        <= 7'd0;
            lastHole      <= 3'd0;
            gameOver      <= 1'b0;
            potFlag       <= 1'b0;
        end else begin
            // A turnEnd landing on SCORE must not toggle: the pot just made
            // keeps the turn, and potFlag stays set for the next turnEnd.
            if (state == SCORE) begin
                potFlag <= 1'b1;
            end else if (turnEnd) begin
                if (!potFlag) begin
                    currentPlayer <= ~currentPlayer;
                end
                potFlag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hitRise && holeValid && !gameOver) begin
                        lastHole    <= holeNumberHit;
                        ballVisible <= 1'b0;
                        sinkFrame   <= 4'd0;
                        state       <= SINKING;
                    end
                end
                SINKING: begin
                    if (startOfFrame) begin
                        if (sinkFrame == LAST_FRAME) begin
                            state <= SCORE;
                        end else begin
                            sinkFrame <= sinkFrame + 4'd1;
                        end
                    end
                end
                SCORE: begin
                    if (currentPlayer != '0) begin
                        score1 <= nextScore;
                    end else begin
                        score0 <= nextScore;
                    end
                    if (reachWin) begin
                        gameOver <= 1'b1;
                    end
                    sinkFrame  <= 4'd0;
                    respawnReq <= 1'b1;
                    state      <= RESPAWN;
                end
                RESPAWN: begin
                    if (respawnAck) begin
                        respawnReq  <= 1'b0;
                        ballVisible <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pocket_event_manager.sv
// Directed bench for pocket_event_manager with a pocketing scoreboard.
module tb_pocket_event_manager;

    localparam int SF = 8;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       holeHit;
    logic [2:0] holeNumberHit;
    logic       turnEnd;
    logic       respawnAck;
    logic       ballVisible;
    logic [3:0] sinkFrame;
    logic       respawnReq;
    logic       currentPlayer;
    logic [6:0] score0;
    logic [6:0] score1;
    logic [2:0] lastHole;
    logic       gameOver;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct packed {
        logic [2:0] hole;
        logic [6:0] s0;
        logic [6:0] s1;
        logic       go;
        logic       cp;
    } exp_t;

    exp_t expq[$];

    always #5 clk = ~clk;

    pocket_event_manager #(
        .SINK_FRAMES (SF),
        .WIN_SCORE   (2),
        .NUM_HOLES   (6)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .holeHit       (holeHit),
        .holeNumberHit (holeNumberHit),
        .turnEnd       (turnEnd),
        .respawnAck    (respawnAck),
        .ballVisible   (ballVisible),
        .sinkFrame     (sinkFrame),
        .respawnReq    (respawnReq),
        .currentPlayer (currentPlayer),
        .score0        (score0),
        .score1        (score1),
        .lastHole      (lastHole),
        .gameOver      (gameOver)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every new respawn request marks a completed pocketing.
    logic reqPrev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (respawnReq === 1'b1 && reqPrev === 1'b0) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pocket: got pocketing on hole %0d expected none", lastHole);
            end else begin
                e = expq.pop_front();
                check("pocket_hole", 32'(lastHole), 32'(e.hole));
                check("pocket_score0", 32'(score0), 32'(e.s0));
                check("pocket_score1", 32'(score1), 32'(e.s1));
                check("pocket_gameover", 32'(gameOver), 32'(e.go));
                check("pocket_player", 32'(currentPlayer), 32'(e.cp));
            end
        end
        reqPrev = respawnReq;
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic pulse_turn();
        turnEnd = 1'b1;
        tick();
        turnEnd = 1'b0;
    endtask

    task automatic ack();
        respawnAck = 1'b1;
        tick();
        respawnAck = 1'b0;
    endtask

    task automatic hit(input logic [2:0] h);
        holeNumberHit = h;
        holeHit       = 1'b1;
        tick();
    endtask

    task automatic sink_frames(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            tick();
            tick();
            sof();
            if (k < SF) check("sink_frame", 32'(sinkFrame), 32'(k));
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (respawnReq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(respawnReq), 32'd1);
    endtask

    task automatic do_reset();
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        holeHit       = 1'b0;
        holeNumberHit = 3'd0;
        turnEnd       = 1'b0;
        respawnAck    = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_visible"}, 32'(ballVisible), 32'd1);
        check({tag, "_sinkframe"}, 32'(sinkFrame), 32'd0);
        check({tag, "_req"}, 32'(respawnReq), 32'd0);
        check({tag, "_player"}, 32'(currentPlayer), 32'd0);
        check({tag, "_score0"}, 32'(score0), 32'd0);
        check({tag, "_score1"}, 32'(score1), 32'd0);
        check({tag, "_lasthole"}, 32'(lastHole), 32'd0);
        check({tag, "_gameover"}, 32'(gameOver), 32'd0);
    endtask

    initial begin
        int start;
        do_reset();
        check_reset_outputs("reset");

        // Stray ack in IDLE does nothing.
        ack();
        check("stray_ack_req", 32'(respawnReq), 32'd0);
        check("stray_ack_visible", 32'(ballVisible), 32'd1);

        // Player 0 pockets hole 3 with holeHit held for 50 cycles.
        expq.push_back('{hole: 3'd3, s0: 7'd1, s1: 7'd0, go: 1'b0, cp: 1'b0});
        start = cyc;
        hit(3'd3);
        check("hit_latency_visible", 32'(ballVisible), 32'd0);
        check("hit_lasthole", 32'(lastHole), 32'd3);
        sink_frames(1, SF);
        wait_req("a_req_raised");
        check("a_hidden_in_respawn", 32'(ballVisible), 32'd0);
        repeat (4) tick();
        check("a_req_held", 32'(respawnReq), 32'd1);
        ack();
        check("a_req_dropped", 32'(respawnReq), 32'd0);
        check("a_visible_again", 32'(ballVisible), 32'd1);
        while (cyc - start < 50) tick();
        holeHit = 1'b0;
        tick();
        check("a_single_pocket_score0", 32'(score0), 32'd1);
        check("a_visible_after_hold", 32'(ballVisible), 32'd1);

        // Out-of-range holes are dropped.
        hit(3'd6);
        check("hole6_visible", 32'(ballVisible), 32'd1);
        holeHit = 1'b0;
        tick();
        hit(3'd7);
        check("hole7_visible", 32'(ballVisible), 32'd1);
        holeHit = 1'b0;
        sof();
        check("invalid_sinkframe", 32'(sinkFrame), 32'd0);
        check("invalid_score0", 32'(score0), 32'd1);
        check("invalid_lasthole", 32'(lastHole), 32'd3);

        // First turnEnd consumes the pot (no toggle), second toggles to 1.
        pulse_turn();
        check("turn_after_pot", 32'(currentPlayer), 32'd0);
        pulse_turn();
        check("turn_no_pot", 32'(currentPlayer), 32'd1);

        // Player 1 pockets hole 0; a second rise on hole 1 mid-sink is ignored.
        expq.push_back('{hole: 3'd0, s0: 7'd1, s1: 7'd1, go: 1'b0, cp: 1'b1});
        hit(3'd0);
        holeHit = 1'b0;
        sink_frames(1, 3);
        hit(3'd1);
        check("second_rise_lasthole", 32'(lastHole), 32'd0);
        holeHit = 1'b0;
        sink_frames(4, SF);
        wait_req("d_req_raised");
        ack();
        check("d_visible_again", 32'(ballVisible), 32'd1);
        pulse_turn();
        check("d_player_keeps_turn", 32'(currentPlayer), 32'd1);
        check("d_score1", 32'(score1), 32'd1);
        pulse_turn();
        check("d_player_toggles", 32'(currentPlayer), 32'd0);

        // Player 0 pockets hole 5 with turnEnd landing on SCORE; reaches WIN_SCORE.
        expq.push_back('{hole: 3'd5, s0: 7'd2, s1: 7'd1, go: 1'b1, cp: 1'b0});
        hit(3'd5);
        holeHit = 1'b0;
        sink_frames(1, SF);
        pulse_turn();
        check("e_no_toggle_on_score", 32'(currentPlayer), 32'd0);
        check("e_gameover", 32'(gameOver), 32'd1);
        wait_req("e_req_raised");
        ack();
        pulse_turn();
        check("e_potflag_kept", 32'(currentPlayer), 32'd0);
        pulse_turn();
        check("e_toggle_after", 32'(currentPlayer), 32'd1);

        // Game over blocks new pocketings.
        hit(3'd2);
        check("go_blocked_visible", 32'(ballVisible), 32'd1);
        check("go_blocked_lasthole", 32'(lastHole), 32'd5);
        holeHit = 1'b0;
        sof();
        check("go_blocked_sinkframe", 32'(sinkFrame), 32'd0);
        check("go_score0_held", 32'(score0), 32'd2);

        // Fresh game, then asynchronous reset in the middle of SINKING.
        do_reset();
        check("reset_clears_gameover", 32'(gameOver), 32'd0);
        hit(3'd4);
        holeHit = 1'b0;
        sink_frames(1, 3);
        #2;
        resetN = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        resetN = 1'b1;
        tick();
        sof();
        check("after_abort_sinkframe", 32'(sinkFrame), 32'd0);
        check("after_abort_visible", 32'(ballVisible), 32'd1);

        repeat (3) tick();
        check("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
